// File: rtl/kmp_fail_func_gen.sv
// KMP failure-function generator: computes the full failure function of a
// latched pattern, one compare/fallback step per clock, with optional ASCII case folding.
//
// state   | meaning
// IDLE_ST | waiting for i_valid; captures pattern, length and nocase
// CALC_ST | one compare or fallback step per cycle
// DONE_ST | result valid and held until i_valid drops
module kmp_fail_func_gen #(
    parameter int MAX_PATTERN = 32,
    parameter int SYM_W       = 8,
    parameter int ADDR_W      = $clog2(MAX_PATTERN)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [MAX_PATTERN*SYM_W-1:0]  pattern,
    input  logic [ADDR_W-1:0]             last_pat_idx,
    input  logic                          i_nocase,
    output logic [MAX_PATTERN*ADDR_W-1:0] o_fail_func,
    output logic                          o_valid,
    output logic                          o_busy,
    output logic [ADDR_W+1:0]             o_steps
);

    localparam int IDLE_B = 0;
    localparam int CALC_B = 1;
    localparam int DONE_B = 2;
    localparam logic [2:0] IDLE_ST = 3'b001;
    localparam logic [2:0] CALC_ST = 3'b010;
    localparam logic [2:0] DONE_ST = 3'b100;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [SYM_W-1:0]  r_pat [MAX_PATTERN];
    logic [ADDR_W-1:0] r_f   [MAX_PATTERN];
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_k;
    logic              r_nocase;
    logic [ADDR_W+1:0] r_steps;
    logic [SYM_W-1:0]  w_sym_i;
    logic [SYM_W-1:0]  w_sym_k;
    logic              w_match;
    logic              w_fallback;
    logic              w_last_step;

    // Folding only makes sense for byte symbols; wider/narrower symbols compare raw.
    function automatic logic [SYM_W-1:0] fold(input logic [SYM_W-1:0] s, input logic nc);
        if (SYM_W == 8 && nc && s >= SYM_W'(8'h41) && s <= SYM_W'(8'h5A))
            return s | SYM_W'(8'h20);
        return s;
    endfunction

    assign w_sym_i     = fold(r_pat[r_i], r_nocase);
    assign w_sym_k     = fold(r_pat[r_k], r_nocase);
    assign w_match     = (w_sym_i == w_sym_k);
    assign w_fallback  = !w_match && (r_k != '0);
    assign w_last_step = !w_fallback && (r_i == r_last);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE_ST;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (1'b1)
            r_state[IDLE_B]: begin
                if (i_valid) w_next = (last_pat_idx == '0) ? DONE_ST : CALC_ST;
            end
            r_state[CALC_B]: begin
                if (!i_valid)        w_next = IDLE_ST;
                else if (w_last_step) w_next = DONE_ST;
            end
            r_state[DONE_B]: begin
                if (!i_valid) w_next = IDLE_ST;
            end
            default: w_next = IDLE_ST;
        endcase
    end

    always_comb begin
        o_valid = r_state[DONE_B];
        o_busy  = r_state[CALC_B];
        o_steps = r_steps;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < MAX_PATTERN; j++) begin
                r_pat[j] <= '0;
                r_f[j]   <= '0;
            end
            r_last   <= '0;
            r_nocase <= 1'b0;
            r_steps  <= '0;
            r_i      <= ADDR_W'(1);
            r_k      <= '0;
        end else if (r_state[IDLE_B] && i_valid) begin
            for (int j = 0; j < MAX_PATTERN; j++) begin
                r_pat[j] <= pattern[j*SYM_W +: SYM_W];
                r_f[j]   <= '0;
            end
            r_last   <= last_pat_idx;
            r_nocase <= i_nocase;
            r_steps  <= '0;
            r_i      <= ADDR_W'(1);
            r_k      <= '0;
        end else if (r_state[CALC_B] && i_valid) begin
            r_steps <= r_steps + (ADDR_W+2)'(1);
            if (w_match) begin
                r_f[r_i] <= r_k + ADDR_W'(1);
                r_k      <= r_k + ADDR_W'(1);
                r_i      <= r_i + ADDR_W'(1);
            end else if (w_fallback) begin
                r_k <= r_f[r_k - ADDR_W'(1)];
            end else begin
                r_f[r_i] <= '0;
                r_i      <= r_i + ADDR_W'(1);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < MAX_PATTERN; g++) begin : g_out
            assign o_fail_func[g*ADDR_W +: ADDR_W] = r_f[g];
        end
    endgenerate

endmodule

// File: tb/tb_kmp_fail_func_gen.sv
// Directed testbench for kmp_fail_func_gen: hand-computed failure functions,
// step counts, latencies, abort, reset and input-isolation scenarios.
module tb_kmp_fail_func_gen;

    localparam int MAXP  = 32;
    localparam int SYM_W = 8;
    localparam int AW    = 5;

    logic                   clk;
    logic                   reset;
    logic                   i_valid;
    logic [MAXP*SYM_W-1:0]  pattern;
    logic [AW-1:0]          last_pat_idx;
    logic                   i_nocase;
    logic [MAXP*AW-1:0]     o_fail_func;
    logic                   o_valid;
    logic                   o_busy;
    logic [AW+1:0]          o_steps;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    kmp_fail_func_gen #(.MAX_PATTERN(MAXP), .SYM_W(SYM_W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .pattern(pattern),
        .last_pat_idx(last_pat_idx), .i_nocase(i_nocase), .o_fail_func(o_fail_func),
        .o_valid(o_valid), .o_busy(o_busy), .o_steps(o_steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MAXP*SYM_W-1:0] pack_str(input string s);
        logic [MAXP*SYM_W-1:0] v;
        v = '0;
        for (int j = 0; j < s.len() && j < MAXP; j++) v[j*SYM_W +: SYM_W] = s[j];
        return v;
    endfunction

    function automatic int f_at(input int j);
        return int'(o_fail_func[j*AW +: AW]);
    endfunction

    // Raises i_valid and counts edges until o_valid; -1 if it never comes.
    task automatic run_until_valid(input int first_edge, output int edges);
        i_valid = 1'b1;
        edges = -1;
        for (int c = first_edge; c <= 200; c++) begin
            tick();
            if (o_valid) begin
                edges = c;
                break;
            end
        end
    endtask

    task automatic release_valid();
        i_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 1'b0; pattern = '0; last_pat_idx = '0; i_nocase = 1'b0;
        tick(); tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: valid=%b busy=%b expected 0 0", o_valid, o_busy);
        end
        n_checks++;
        if (o_steps !== '0 || o_fail_func !== '0) begin
            n_errors++; $display("FAIL reset_data: steps=%0d f=%h expected 0", o_steps, o_fail_func);
        end
        reset = 1'b0;
        tick();
    endtask

    // Directed vector: expected f entries in exp_q, higher entries must read 0.
    task automatic test_vector(input string name, input string pat, input int last,
                               input bit nc, input int exp_steps);
        int edges;
        pattern = pack_str(pat); last_pat_idx = AW'(last); i_nocase = nc;
        run_until_valid(1, edges);
        n_checks++;
        if (edges !== exp_steps + 1) begin
            n_errors++; $display("FAIL %s_latency: valid after edge %0d expected %0d", name, edges, exp_steps + 1);
        end
        n_checks++;
        if (int'(o_steps) !== exp_steps || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL %s_steps: steps=%0d busy=%b expected %0d 0", name, o_steps, o_busy, exp_steps);
        end
        for (int j = 0; j < MAXP; j++) begin
            int e;
            e = (j < exp_q.size()) ? exp_q[j] : 0;
            n_checks++;
            if (f_at(j) !== e) begin
                n_errors++; $display("FAIL %s_f[%0d]: got %0d expected %0d", name, j, f_at(j), e);
            end
        end
        release_valid();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_errors++; $display("FAIL %s_release: valid=%b expected 0", name, o_valid);
        end
    endtask

    task automatic test_basic();
        exp_q = '{0, 0, 1, 2};
        test_vector("abab", "ABAB", 3, 1'b0, 3);
        exp_q = '{0, 1, 0, 1, 2, 2};
        test_vector("aabaaa", "AABAAA", 5, 1'b0, 7);
    endtask

    task automatic test_nocase();
        string s_at;
        exp_q = '{0, 0, 1, 2};
        test_vector("nocase_on", "abAB", 3, 1'b1, 3);
        exp_q = '{0, 0, 0, 0};
        test_vector("nocase_off", "abAB", 3, 1'b0, 3);
        exp_q = '{0, 1};
        test_vector("nocase_z", "zZ", 1, 1'b1, 1);
        s_at = "@@@@";
        s_at[1] = 8'h60;
        s_at[3] = 8'h60;
        exp_q = '{0, 0, 1, 2};
        test_vector("nocase_at", s_at, 3, 1'b1, 3);
        exp_q = '{0, 0, 1, 2};
        test_vector("nocase_brk", "[{[{", 3, 1'b1, 3);
    endtask

    task automatic test_single();
        exp_q = '{0};
        test_vector("single", "Q", 0, 1'b0, 0);
    endtask

    task automatic test_all_a();
        string s;
        s = "";
        for (int j = 0; j < MAXP; j++) s = {s, "A"};
        exp_q = {};
        for (int j = 0; j < MAXP; j++) exp_q.push_back(j);
        test_vector("all_a", s, MAXP - 1, 1'b0, MAXP - 1);
    endtask

    task automatic test_change_in_calc();
        int edges;
        pattern = pack_str("AABAAA"); last_pat_idx = AW'(5); i_nocase = 1'b0;
        i_valid = 1'b1;
        tick();
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_errors++; $display("FAIL change_busy: busy=%b expected 1", o_busy);
        end
        pattern = pack_str("ZZZZZZ"); last_pat_idx = AW'(1); i_nocase = 1'b1;
        run_until_valid(2, edges);
        n_checks++;
        if (edges !== 8 || int'(o_steps) !== 7) begin
            n_errors++; $display("FAIL change_timing: edge=%0d steps=%0d expected 8 7", edges, o_steps);
        end
        n_checks++;
        if (f_at(1) !== 1 || f_at(2) !== 0 || f_at(4) !== 2 || f_at(5) !== 2) begin
            n_errors++; $display("FAIL change_f: f1..5=%0d %0d %0d %0d %0d expected 1 0 1 2 2",
                                 f_at(1), f_at(2), f_at(3), f_at(4), f_at(5));
        end
    endtask

    // Continues from DONE_ST left by test_change_in_calc.
    task automatic test_drop_in_done();
        tick();
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_errors++; $display("FAIL done_hold: valid=%b expected 1", o_valid);
        end
        i_valid = 1'b0;
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL drop_flags: valid=%b busy=%b expected 0 0", o_valid, o_busy);
        end
        n_checks++;
        if (int'(o_steps) !== 7 || f_at(5) !== 2 || f_at(3) !== 1) begin
            n_errors++; $display("FAIL drop_hold: steps=%0d f5=%0d f3=%0d expected 7 2 1", o_steps, f_at(5), f_at(3));
        end
        tick();
        pattern = pack_str("AA"); last_pat_idx = AW'(1); i_nocase = 1'b0;
        i_valid = 1'b1;
        tick();
        n_checks++;
        if (o_busy !== 1'b1 || int'(o_steps) !== 0 || f_at(3) !== 0) begin
            n_errors++; $display("FAIL b2b_capture: busy=%b steps=%0d f3=%0d expected 1 0 0", o_busy, o_steps, f_at(3));
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || f_at(1) !== 1 || int'(o_steps) !== 1) begin
            n_errors++; $display("FAIL b2b_result: valid=%b f1=%0d steps=%0d expected 1 1 1", o_valid, f_at(1), o_steps);
        end
        release_valid();
    endtask

    task automatic test_abort();
        pattern = pack_str("AABAAA"); last_pat_idx = AW'(5); i_nocase = 1'b0;
        i_valid = 1'b1;
        tick();
        tick();
        i_valid = 1'b0;
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_flags: valid=%b busy=%b expected 0 0", o_valid, o_busy);
        end
        n_checks++;
        if (int'(o_steps) !== 1 || f_at(1) !== 1) begin
            n_errors++; $display("FAIL abort_partial: steps=%0d f1=%0d expected 1 1", o_steps, f_at(1));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        pattern = pack_str("AABAAA"); last_pat_idx = AW'(5); i_nocase = 1'b0;
        i_valid = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_steps !== '0 || o_fail_func !== '0) begin
            n_errors++; $display("FAIL reset_mid: valid=%b busy=%b steps=%0d f=%h expected all 0",
                                 o_valid, o_busy, o_steps, o_fail_func);
        end
        reset = 1'b0;
        i_valid = 1'b0;
        tick();
        exp_q = '{0, 0, 1, 2};
        test_vector("after_reset", "ABAB", 3, 1'b0, 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nocase();
        test_all_a();
        test_single();
        test_change_in_calc();
        test_drop_in_done();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
